// File: rtl/branch_target_table_if.sv
// Lookup, single-write and bulk-load signal bundle for branch_target_table.
interface branch_target_table_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TGT_W  = 10
);
  logic [ADDR_W-1:0] addr;
  logic [TGT_W-1:0]  target_c;
  logic              hit_c;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [TGT_W-1:0]  wr_data;
  logic              ld_start;
  logic              ld_valid;
  logic [TGT_W-1:0]  ld_data;
  logic              ld_ready;
  logic              busy;
  logic              ld_done;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output addr, wr_en, wr_addr, wr_data, ld_start, ld_valid, ld_data,
    input  target_c, hit_c, ld_ready, busy, ld_done, ld_count
  );

  modport slave (
    input  addr, wr_en, wr_addr, wr_data, ld_start, ld_valid, ld_data,
    output target_c, hit_c, ld_ready, busy, ld_done, ld_count
  );
endinterface

// File: rtl/branch_target_table.sv
// Writable branch-target lookup table with single-entry writes and streamed bulk load.
// Optional macro BTT_BYPASS_EN forwards same-cycle writes to the lookup port.
module branch_target_table #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TGT_W  = 10
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  branch_target_table_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TGT_W-1:0]  data_q [DEPTH];
  logic              ld_ready_q, busy_q, ld_done_q;

  logic              clr_valid;
  logic              beat;
  logic              wr_single;
  logic              we_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [TGT_W-1:0]  wdata_c;
  logic              lookup_hit;
  logic [TGT_W-1:0]  lookup_tgt;

  // Next-state logic; a start pulse takes priority over a same-cycle single write.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    clr_valid = 1'b0;
    beat      = 1'b0;
    wr_single = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ld_start) begin
          state_d   = LOAD;
          clr_valid = 1'b1;
          ptr_d     = '0;
          cnt_d     = '0;
        end else if (bus.wr_en) begin
          wr_single = 1'b1;
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          beat  = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
          if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared write port for single writes and load beats.
  always_comb begin
    we_c    = beat | wr_single;
    waddr_c = beat ? ptr_q : bus.wr_addr;
    wdata_c = beat ? bus.ld_data : bus.wr_data;
    valid_d = valid_q;
    if (clr_valid) valid_d = '0;
    if (we_c) valid_d[waddr_c] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      ld_ready_q <= (state_d == LOAD);
      busy_q     <= (state_d != IDLE);
      ld_done_q  <= (state_d == DONE);
    end
  end

  // Target storage carries no reset; the valid bits gate every read.
  always_ff @(posedge clk_i) begin
    if (we_c) data_q[waddr_c] <= wdata_c;
  end

  always_comb begin
    lookup_hit = valid_q[bus.addr];
    lookup_tgt = lookup_hit ? data_q[bus.addr] : '0;
`ifdef BTT_BYPASS_EN
    if (we_c && (waddr_c == bus.addr)) begin
      lookup_hit = 1'b1;
      lookup_tgt = wdata_c;
    end
`endif
  end

  assign bus.hit_c    = lookup_hit;
  assign bus.target_c = lookup_tgt;
  assign bus.ld_ready = ld_ready_q;
  assign bus.busy     = busy_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_count = cnt_q;
endmodule

// File: doc/branch_target_table.md
# branch_target_table

Programmable branch-target lookup table for the single-cycle core: a parametrised, writable replacement for the fixed branch-target ROM. Fetch logic indexes it with the branch immediate field and receives the absolute target PC in the same cycle. Entries are written singly through a debug/patch port or bulk-loaded from a streaming valid/ready source at boot. A per-entry valid bit reports hit/miss.

## Interface
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W entries
- TGT_W, 10, target PC width
- Clk  in  1  clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Addr  in  ADDR_W  lookup index
- Target  out  TGT_W  target PC for Addr, combinational; 0 on miss
- Hit  out  1  entry at Addr is valid, combinational
- Wr_en  in  1  single-entry write strobe
- Wr_addr  in  ADDR_W  single-entry write index
- Wr_data  in  TGT_W  single-entry write data
- Ld_start  in  1  begin bulk load (one-cycle pulse)
- Ld_valid  in  1  bulk-load beat present
- Ld_data  in  TGT_W  bulk-load beat data
- Ld_ready  out  1  table accepts a beat this cycle
- Busy  out  1  bulk load in progress
- Ld_done  out  1  one-cycle pulse after last entry written
- Ld_count  out  ADDR_W+1  entries written by current/last bulk load

## Operation
- Storage: DEPTH x TGT_W data array plus DEPTH valid bits. Data array not reset; valid bits, FSM, pointer, Ld_count, Ld_done cleared by Reset_n.
- Lookup: Hit = valid[Addr]; Target = Hit ? data[Addr] : 0.
- FSM states IDLE, LOAD, DONE.
  - IDLE: Ld_ready=0, Busy=0. Ld_start=1 -> LOAD; same edge clears all valid bits, pointer=0, Ld_count=0.
  - LOAD: Ld_ready=1, Busy=1. Ld_valid&Ld_ready writes Ld_data to data[ptr], sets valid[ptr], ptr++, Ld_count++. Beat at ptr=DEPTH-1 -> DONE. Ld_start ignored.
  - DONE: Ld_ready=0, Busy=1, Ld_done=1 for exactly this cycle -> IDLE.
- Single write: in IDLE, Wr_en writes Wr_data to data[Wr_addr], sets valid[Wr_addr]. In LOAD/DONE Wr_en dropped (no effect). Wr_en and Ld_start in same IDLE cycle: Ld_start wins, write dropped.
- Pointer wraps naturally at DEPTH; Ld_count saturates at DEPTH and holds until next Ld_start.
- Reset asserted mid-load: immediate return to IDLE, all entries invalid, Ld_count=0; partial load discarded.

## Timing
- Reset values: Target=0, Hit=0, Ld_ready=0, Busy=0, Ld_done=0, Ld_count=0.
- Read latency 0 (combinational from Addr and array).
- Write latency 1: entry written at edge N visible on Target/Hit from after edge N.
- Ld_ready asserted first cycle after Ld_start edge; beats accepted at 1/cycle max; Ld_valid low stalls without penalty.
- Minimum full load: DEPTH+2 cycles from Ld_start to Ld_done pulse end.

## Configuration
- BTT_BYPASS_EN defined: write-to-read forwarding. When an accepted write (single or bulk beat) targets Addr in the current cycle, Target shows the write data and Hit=1 combinationally in that same cycle.
- Undefined: no forwarding; Target/Hit reflect array state before the edge (old value/miss until next cycle).

## Test plan
- Reset then sweep Addr 0..31 -> Hit=0, Target=0 all entries; Ld_ready=0, Busy=0.
- IDLE write Wr_addr=6, Wr_data=403; next cycle Addr=6 -> Hit=1, Target=403; Addr=7 -> Hit=0, Target=0.
- Ld_start, stream 32 beats data=i*3+11 with Ld_valid deasserted every 4th cycle -> Ld_done single pulse, Ld_count=32, Addr=31 -> Target=104; Wr_en during load leaves entry 5 = 26.
- Ld_start after prior writes, assert Reset_n low after 10 beats -> Busy=0, Ld_count=0, Addr=3 -> Hit=0.
- Same-cycle Wr_addr=Addr=30, Wr_data=322 -> Target=322/Hit=1 with BTT_BYPASS_EN; Target=0/Hit=0 without, 322 next cycle.
- Wr_en and Ld_start same cycle, Wr_addr=1, Wr_data=179 -> load starts, entry 1 not valid until its load beat.
